// File: rtl/text_fetcher.sv
// Text-mode frame fetcher: walks the character screen once per scan line,
// looks up glyph bytes in font memory and streams them out with line/frame markers.
module text_fetcher #(
   parameter logic [14:0] SCREEN_BASE = 15'h1000,
   parameter logic [14:0] FONT_BASE   = 15'h0900,
   parameter int unsigned COLS        = 40,
   parameter int unsigned ROWS        = 25,
   parameter logic [7:0]  FIRST_CHAR  = 8'h20
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [14:0] mem_addr,
   output logic        mem_rd,
   input  logic        mem_grant,
   input  logic [7:0]  mem_rd_data,
   output logic [7:0]  pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_sol,
   output logic        pix_sof
);

   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [2:0] {
      IDLE, CHAR_REQ, CHAR_WAIT, FONT_REQ, FONT_WAIT, EMIT
   } state_t;

   state_t state, state_nxt;

   logic [RW-1:0] row;
   logic [2:0]    scan;
   logic [CW-1:0] col;
   logic [7:0]    code;
   logic [7:0]    glyph_idx;
   logic [14:0]   screen_addr;
   logic [14:0]   font_addr;
   logic          col_last, scan_last, row_last, frame_last, accept;

   assign col_last   = (col == CW'(COLS - 1));
   assign scan_last  = (scan == 3'd7);
   assign row_last   = (row == RW'(ROWS - 1));
   assign frame_last = col_last && scan_last && row_last;
   assign accept     = (state == EMIT) && pix_ready;

   // Address arithmetic is modulo 2^15 by construction of the 15-bit sums.
   assign glyph_idx   = code - FIRST_CHAR;
   assign screen_addr = SCREEN_BASE + 15'(row) * 15'(COLS) + 15'(col);
   assign font_addr   = FONT_BASE + {4'b0000, glyph_idx, 3'b000} + {12'd0, scan};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_rd    = 1'b0;
      mem_addr  = '0;
      case (state)
         IDLE:      if (start) state_nxt = CHAR_REQ;
         CHAR_REQ: begin
            mem_rd   = 1'b1;
            mem_addr = screen_addr;
            if (mem_grant) state_nxt = CHAR_WAIT;
         end
         CHAR_WAIT: state_nxt = (mem_rd_data < FIRST_CHAR) ? EMIT : FONT_REQ;
         FONT_REQ: begin
            mem_rd   = 1'b1;
            mem_addr = font_addr;
            if (mem_grant) state_nxt = FONT_WAIT;
         end
         FONT_WAIT: state_nxt = EMIT;
         EMIT:      if (pix_ready) state_nxt = frame_last ? IDLE : CHAR_REQ;
         default:   state_nxt = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign pix_valid = (state == EMIT);
   assign pix_sol   = pix_valid && (col == '0);
   assign pix_sof   = pix_sol && (row == '0) && (scan == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row      <= '0;
         scan     <= '0;
         col      <= '0;
         code     <= '0;
         pix_data <= '0;
         done     <= 1'b0;
      end else begin
         done <= accept && frame_last;
         case (state)
            IDLE: if (start) begin
               row  <= '0;
               scan <= '0;
               col  <= '0;
            end
            CHAR_WAIT: begin
               code <= mem_rd_data;
               if (mem_rd_data < FIRST_CHAR) pix_data <= '0;
            end
            FONT_WAIT: pix_data <= mem_rd_data;
            EMIT: if (pix_ready) begin
               if (col_last) begin
                  col <= '0;
                  if (scan_last) begin
                     scan <= '0;
                     row  <= row_last ? '0 : row + RW'(1);
                  end else begin
                     scan <= scan + 3'd1;
                  end
               end else begin
                  col <= col + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_text_fetcher.sv
// Scoreboarded bench for text_fetcher: a memory model answers reads, expected
// bytes for a frame are queued at start and checked at each consumer handshake.
module tb_text_fetcher;

   localparam logic [14:0] SCREEN = 15'h1000;
   localparam logic [14:0] FONT   = 15'h0900;
   localparam int          NCOL   = 40;
   localparam int          NROW   = 25;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic        busy, done;
   logic [14:0] mem_addr;
   logic        mem_rd;
   logic        mem_grant = 1'b1;
   logic [7:0]  mem_rd_data = 8'h00;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic        pix_ready = 1'b1;
   logic        pix_sol, pix_sof;

   always #5 clk = ~clk;

   text_fetcher #(
      .SCREEN_BASE(SCREEN),
      .FONT_BASE  (FONT),
      .COLS       (NCOL),
      .ROWS       (NROW),
      .FIRST_CHAR (8'h20)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_grant  (mem_grant),
      .mem_rd_data(mem_rd_data),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_sol    (pix_sol),
      .pix_sof    (pix_sof)
   );

   logic [7:0] mem [0:32767];
   always @(posedge clk) if (mem_rd && mem_grant) mem_rd_data <= mem[mem_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      logic       sol;
      logic       sof;
   } exp_t;

   exp_t        exp_q[$];
   logic [14:0] addr_log[$];
   int          gaps[$];
   int total = 0, bad = 0;
   int acc_count = 0, sol_count = 0, sof_count = 0, last_acc_cyc = 0;
   int done_count = 0, done_cyc = 0;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (mem_rd && mem_grant) addr_log.push_back(mem_addr);
         if (done) begin
            done_count++;
            done_cyc = cyc;
         end
         if (pix_valid && pix_ready) begin
            exp_t e;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL scoreboard_unexpected got data=%h sol=%b sof=%b want nothing", pix_data, pix_sol, pix_sof);
            end else begin
               e = exp_q.pop_front();
               if ({pix_data, pix_sol, pix_sof} !== {e.data, e.sol, e.sof}) begin
                  bad++;
                  $display("FAIL scoreboard byte=%0d got data=%h sol=%b sof=%b want data=%h sol=%b sof=%b",
                           acc_count, pix_data, pix_sol, pix_sof, e.data, e.sol, e.sof);
               end
            end
            gaps.push_back(cyc - last_acc_cyc);
            last_acc_cyc = cyc;
            acc_count++;
            if (pix_sol) sol_count++;
            if (pix_sof) sof_count++;
         end
      end
   endtask

   task automatic init_mem();
      for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < NCOL * NROW; i++)
         mem[int'(SCREEN) + i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31))
                                                               : 8'($urandom_range(32, 255));
      mem['h1000] = 8'h41;
      mem['h1001] = 8'h0D;
      mem['h1002] = 8'h42;
      mem['h0A08] = 8'h18;
   endtask

   task automatic push_frame();
      for (int r = 0; r < NROW; r++)
         for (int s = 0; s < 8; s++)
            for (int c = 0; c < NCOL; c++) begin
               exp_t       e;
               logic [7:0] ch;
               ch     = mem['h1000 + r * NCOL + c];
               e.data = (ch < 8'h20) ? 8'h00 : mem['h0900 + (int'(ch) - 32) * 8 + s];
               e.sol  = (c == 0);
               e.sof  = (r == 0) && (s == 0) && (c == 0);
               exp_q.push_back(e);
            end
   endtask

   task automatic pulse_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      start = 1'b1;
      tick();
      tick();
      total++;
      if ({busy, done, mem_rd, mem_addr, pix_valid, pix_data, pix_sol, pix_sof} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got busy=%b done=%b rd=%b addr=%h valid=%b data=%h sol=%b sof=%b want all zero",
                  busy, done, mem_rd, mem_addr, pix_valid, pix_data, pix_sol, pix_sof);
      end
      start = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (3) tick();
      total++;
      if ({busy, mem_rd, pix_valid} !== 3'b000) begin
         bad++;
         $display("FAIL idle_no_start got busy=%b rd=%b valid=%b want 000", busy, mem_rd, pix_valid);
      end
   endtask

   task automatic test_full_frame();
      int          base_acc, base_sol, base_sof, base_done, n;
      logic [14:0] want_addr [4];
      want_addr[0] = 15'h1000;
      want_addr[1] = 15'h0A08;
      want_addr[2] = 15'h1001;
      want_addr[3] = 15'h1002;
      base_acc = acc_count; base_sol = sol_count; base_sof = sof_count; base_done = done_count;
      addr_log.delete();
      gaps.delete();
      push_frame();
      pulse_start();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_after_start got %b want 1", busy);
      end
      n = 0;
      while (done_count == base_done && n < 60000) begin
         tick();
         n++;
      end
      total++;
      if (done_count == base_done) begin
         bad++;
         $display("FAIL frame_timeout got no done after %0d cycles want done", n);
      end
      tick();
      total++;
      if (acc_count - base_acc != 8000) begin
         bad++;
         $display("FAIL frame_bytes got %0d want 8000", acc_count - base_acc);
      end
      total++;
      if (sol_count - base_sol != 200) begin
         bad++;
         $display("FAIL frame_sol got %0d want 200", sol_count - base_sol);
      end
      total++;
      if (sof_count - base_sof != 1) begin
         bad++;
         $display("FAIL frame_sof got %0d want 1", sof_count - base_sof);
      end
      total++;
      if (done_cyc != last_acc_cyc + 1) begin
         bad++;
         $display("FAIL done_timing got cycle %0d want %0d", done_cyc, last_acc_cyc + 1);
      end
      total++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL frame_end got busy=%b left=%0d want busy=0 left=0", busy, exp_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (addr_log.size() <= i) begin
            bad++;
            $display("FAIL read_addr%0d got none want %h", i, want_addr[i]);
         end else if (addr_log[i] !== want_addr[i]) begin
            bad++;
            $display("FAIL read_addr%0d got %h want %h", i, addr_log[i], want_addr[i]);
         end
      end
      total++;
      if (gaps.size() < 3 || gaps[1] != 3 || gaps[2] != 5) begin
         bad++;
         $display("FAIL byte_gaps got %0d/%0d want 3/5",
                  (gaps.size() > 1) ? gaps[1] : -1, (gaps.size() > 2) ? gaps[2] : -1);
      end
   endtask

   task automatic test_ready_stall(output int frame_base);
      logic [9:0] snap;
      int         n;
      frame_base = acc_count;
      exp_q.delete();
      push_frame();
      pulse_start();
      tick();
      pulse_start();
      n = 0;
      while (!(acc_count - frame_base >= 20 && pix_valid) && n < 1000) begin
         tick();
         n++;
      end
      total++;
      if (!pix_valid) begin
         bad++;
         $display("FAIL ready_stall_setup got valid=%b want 1", pix_valid);
      end
      pix_ready = 1'b0;
      snap = {pix_data, pix_sol, pix_sof};
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if ({pix_valid, mem_rd, pix_data, pix_sol, pix_sof} !== {1'b1, 1'b0, snap}) begin
            bad++;
            $display("FAIL ready_stall cyc=%0d got valid=%b rd=%b data/sol/sof=%h want 1 0 %h",
                     i, pix_valid, mem_rd, {pix_data, pix_sol, pix_sof}, snap);
         end
      end
      pix_ready = 1'b1;
   endtask

   task automatic test_grant_stall();
      logic [14:0] held;
      logic [7:0]  want;
      int          n;
      n = 0;
      while (!(mem_rd && mem_addr < SCREEN) && n < 400) begin
         tick();
         n++;
      end
      mem_grant = 1'b0;
      held = mem_addr;
      want = mem[held];
      for (int i = 0; i < 7; i++) begin
         tick();
         total++;
         if (mem_rd !== 1'b1 || mem_addr !== held) begin
            bad++;
            $display("FAIL grant_stall cyc=%0d got rd=%b addr=%h want 1 %h", i, mem_rd, mem_addr, held);
         end
      end
      mem_grant = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!pix_valid && n < 10);
      total++;
      if (pix_valid !== 1'b1 || pix_data !== want) begin
         bad++;
         $display("FAIL grant_stall_byte got valid=%b data=%h want 1 %h", pix_valid, pix_data, want);
      end
   endtask

   task automatic test_reset_mid_frame(input int frame_base);
      int n;
      n = 0;
      while (acc_count - frame_base < 1234 && n < 20000) begin
         tick();
         n++;
      end
      reset_n = 1'b0;
      #1;
      total++;
      if ({busy, done, mem_rd, mem_addr, pix_valid, pix_data, pix_sol, pix_sof} !== '0) begin
         bad++;
         $display("FAIL midframe_reset got busy=%b rd=%b addr=%h valid=%b data=%h sol=%b sof=%b want all zero",
                  busy, mem_rd, mem_addr, pix_valid, pix_data, pix_sol, pix_sof);
      end
      tick();
      exp_q.delete();
      reset_n = 1'b1;
      repeat (2) tick();
      addr_log.delete();
      push_frame();
      pulse_start();
      n = 0;
      while (!pix_valid && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (addr_log.size() == 0 || addr_log[0] !== 15'h1000 || pix_sof !== 1'b1 || pix_sol !== 1'b1) begin
         bad++;
         $display("FAIL restart got addr=%h sof=%b sol=%b want 1000 1 1",
                  (addr_log.size() > 0) ? addr_log[0] : 15'h7fff, pix_sof, pix_sol);
      end
      tick();
      reset_n = 1'b0;
      tick();
      exp_q.delete();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      int fb;
      fork
         monitor();
      join_none
      init_mem();
      test_reset();
      test_full_frame();
      test_ready_stall(fb);
      test_grant_stall();
      test_reset_mid_frame(fb);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
